// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding and player constants for the pong match controller
package pong_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SERVE      = 3'd1,
    S_RALLY      = 3'd2,
    S_POINT      = 3'd3,
    S_SET_DONE   = 3'd4,
    S_MATCH_OVER = 3'd5
  } state_e;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

endpackage

// File: rtl/score_counter.sv
// rtl/score_counter.sv - saturating up-counter with clear and target flag
module score_counter #(
  parameter int SCORE_W = 4,
  parameter int TARGET  = 7
) (
  input  logic               clk_1ms,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] cnt,
  output logic               at_target
);

  localparam logic [SCORE_W-1:0] TGT = SCORE_W'(TARGET);

  logic [SCORE_W-1:0] cnt_q;
  logic [SCORE_W-1:0] cnt_d;

  assign at_target = (cnt_q == TGT);
  assign cnt       = cnt_q;

  // clear wins over increment; the count holds once it reaches the target
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_target) begin
      cnt_d = cnt_q + SCORE_W'(1);
    end
  end

  // count register
  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - serve/rally/point sequencing and score keeping for a pong match
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 7,
  parameter int SETS_TO_WIN = 2,
  parameter int SERVE_DELAY = 500,
  parameter int DLY_W       = 10
) (
  input  logic               clk_1ms,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               p1_point,
  input  logic               p2_point,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [SCORE_W-1:0] p1_sets,
  output logic [SCORE_W-1:0] p2_sets,
  output logic               ball_enable,
  output logic               serve_side,
  output logic               game_end,
  output logic               winner
);

  // counter value loaded on entry to SERVE so that SERVE spans SERVE_DELAY unpaused cycles
  localparam logic [DLY_W-1:0]   DLY_LOAD = DLY_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] SET_LAST = SCORE_W'(SETS_TO_WIN - 1);

  state_e            state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              start_q;
  logic              pw_q, pw_d;
  logic              serve_side_q, serve_side_d;
  logic              game_end_q, game_end_d;
  logic              winner_q, winner_d;

  logic              start_rise;
  logic              pt_clr, set_clr;
  logic              p1_inc, p2_inc, s1_inc, s2_inc;
  logic              p1_at, p2_at, s1_at, s2_at;
  logic              unused_sets_at;
  logic [SCORE_W-1:0] set_cur;

  assign start_rise     = start & ~start_q;
  assign set_cur        = pw_q ? p2_sets : p1_sets;
  assign unused_sets_at = s1_at | s2_at;

  score_counter #(.SCORE_W(SCORE_W), .TARGET(WIN_SCORE)) u_p1_pts (
    .clk_1ms(clk_1ms), .reset(reset), .clr(pt_clr), .inc(p1_inc), .cnt(p1_score), .at_target(p1_at));
  score_counter #(.SCORE_W(SCORE_W), .TARGET(WIN_SCORE)) u_p2_pts (
    .clk_1ms(clk_1ms), .reset(reset), .clr(pt_clr), .inc(p2_inc), .cnt(p2_score), .at_target(p2_at));
  score_counter #(.SCORE_W(SCORE_W), .TARGET(SETS_TO_WIN)) u_p1_sets (
    .clk_1ms(clk_1ms), .reset(reset), .clr(set_clr), .inc(s1_inc), .cnt(p1_sets), .at_target(s1_at));
  score_counter #(.SCORE_W(SCORE_W), .TARGET(SETS_TO_WIN)) u_p2_sets (
    .clk_1ms(clk_1ms), .reset(reset), .clr(set_clr), .inc(s2_inc), .cnt(p2_sets), .at_target(s2_at));

  // next-state, serve timer and scoring strobes
  always_comb begin
    state_d      = state_q;
    dly_d        = dly_q;
    pw_d         = pw_q;
    serve_side_d = serve_side_q;
    game_end_d   = game_end_q;
    winner_d     = winner_q;
    pt_clr       = 1'b0;
    set_clr      = 1'b0;
    p1_inc       = 1'b0;
    p2_inc       = 1'b0;
    s1_inc       = 1'b0;
    s2_inc       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          pt_clr       = 1'b1;
          set_clr      = 1'b1;
          serve_side_d = P1;
          dly_d        = DLY_LOAD;
          state_d      = S_SERVE;
        end
      end
      S_SERVE: begin
        if (!pause) begin
          if (dly_q == '0) begin
            state_d = S_RALLY;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
      end
      S_RALLY: begin
        if (!pause) begin
          if (p1_point && p2_point) begin
            dly_d   = DLY_LOAD;
            state_d = S_SERVE;
          end else if (p1_point) begin
            p1_inc  = 1'b1;
            pw_d    = P1;
            state_d = S_POINT;
          end else if (p2_point) begin
            p2_inc  = 1'b1;
            pw_d    = P2;
            state_d = S_POINT;
          end
        end
      end
      S_POINT: begin
        serve_side_d = ~pw_q;
        if (pw_q ? p2_at : p1_at) begin
          state_d = S_SET_DONE;
        end else begin
          dly_d   = DLY_LOAD;
          state_d = S_SERVE;
        end
      end
      S_SET_DONE: begin
        s1_inc = (pw_q == P1);
        s2_inc = (pw_q == P2);
        pt_clr = 1'b1;
        if (set_cur == SET_LAST) begin
          winner_d   = pw_q;
          game_end_d = 1'b1;
          state_d    = S_MATCH_OVER;
        end else begin
          dly_d   = DLY_LOAD;
          state_d = S_SERVE;
        end
      end
      S_MATCH_OVER: begin
        if (start_rise) begin
          pt_clr       = 1'b1;
          set_clr      = 1'b1;
          game_end_d   = 1'b0;
          serve_side_d = P1;
          dly_d        = DLY_LOAD;
          state_d      = S_SERVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers; start_q keeps tracking the button during reset so a held button cannot start a match
  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dly_q        <= '0;
      start_q      <= start;
      pw_q         <= 1'b0;
      serve_side_q <= 1'b0;
      game_end_q   <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      start_q      <= start;
      pw_q         <= pw_d;
      serve_side_q <= serve_side_d;
      game_end_q   <= game_end_d;
      winner_q     <= winner_d;
    end
  end

  assign state       = state_q;
  assign serve_side  = serve_side_q;
  assign game_end    = game_end_q;
  assign winner      = winner_q;
  assign ball_enable = (state_q == S_RALLY) & ~pause;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - scoreboard bench for pong_match_ctrl
module tb_pong_match_ctrl;

  localparam int SW = 4;
  localparam int WS = 3;
  localparam int ST = 2;
  localparam int SD = 4;

  localparam logic [2:0] E_IDLE  = 3'd0;
  localparam logic [2:0] E_SERVE = 3'd1;
  localparam logic [2:0] E_RALLY = 3'd2;
  localparam logic [2:0] E_POINT = 3'd3;
  localparam logic [2:0] E_SET   = 3'd4;
  localparam logic [2:0] E_MO    = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic p1p = 1'b0;
  logic p2p = 1'b0;
  logic [2:0] state;
  logic [SW-1:0] p1_score, p2_score, p1_sets, p2_sets;
  logic ball_enable, serve_side, game_end, winner;

  pong_match_ctrl #(.SCORE_W(SW), .WIN_SCORE(WS), .SETS_TO_WIN(ST), .SERVE_DELAY(SD), .DLY_W(10)) dut (
    .clk_1ms(clk), .reset(reset), .start(start), .pause(pause),
    .p1_point(p1p), .p2_point(p2p), .state(state),
    .p1_score(p1_score), .p2_score(p2_score), .p1_sets(p1_sets), .p2_sets(p2_sets),
    .ball_enable(ball_enable), .serve_side(serve_side), .game_end(game_end), .winner(winner));

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [2:0] st;
    logic [SW-1:0] p1, p2, s1, s2;
    logic be, ss, ge, w;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  int m_p1 = 0, m_p2 = 0, m_s1 = 0, m_s2 = 0;
  logic m_ss = 1'b0, m_ge = 1'b0, m_w = 1'b0;

  // monitor: one expectation consumed per falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic ok;
      e = sb.pop_front();
      ok = (state == e.st) && (p1_score == e.p1) && (p2_score == e.p2) &&
           (p1_sets == e.s1) && (p2_sets == e.s2) && (ball_enable == e.be) &&
           (serve_side == e.ss) && (game_end == e.ge) && (!e.ge || winner == e.w);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s: got st=%0d sc=%0d/%0d sets=%0d/%0d be=%0b ss=%0b ge=%0b w=%0b, want st=%0d sc=%0d/%0d sets=%0d/%0d be=%0b ss=%0b ge=%0b w=%0b",
                 e.name, state, p1_score, p2_score, p1_sets, p2_sets, ball_enable, serve_side, game_end, winner,
                 e.st, e.p1, e.p2, e.s1, e.s2, e.be, e.ss, e.ge, e.w);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [2:0] st, input logic be);
    exp_t e;
    e.name = n; e.st = st; e.be = be;
    e.p1 = SW'(m_p1); e.p2 = SW'(m_p2); e.s1 = SW'(m_s1); e.s2 = SW'(m_s2);
    e.ss = m_ss; e.ge = m_ge; e.w = m_w;
    sb.push_back(e);
  endtask

  // push a check between edges and let the monitor consume it before moving on
  task automatic chk_mid(input string n, input logic [2:0] st, input logic be);
    chk(n, st, be);
    @(negedge clk);
    #1;
  endtask

  // called with SERVE entry already checked; expects SD-1 more SERVE cycles then RALLY
  task automatic serve_phase(input string n);
    for (int i = 1; i < SD; i++) begin
      tick();
      chk(n, E_SERVE, 1'b0);
    end
    tick();
    chk({n, "_rally"}, E_RALLY, 1'b1);
  endtask

  task automatic point(input int who);
    int pts;
    if (who == 1) p1p = 1'b1; else p2p = 1'b1;
    tick();
    p1p = 1'b0; p2p = 1'b0;
    if (who == 1) m_p1++; else m_p2++;
    chk("point_state", E_POINT, 1'b0);
    tick();
    m_ss = (who == 1);
    pts = (who == 1) ? m_p1 : m_p2;
    if (pts == WS) begin
      chk("set_done", E_SET, 1'b0);
      tick();
      if (who == 1) m_s1++; else m_s2++;
      m_p1 = 0; m_p2 = 0;
      if (((who == 1) ? m_s1 : m_s2) == ST) begin
        m_ge = 1'b1;
        m_w  = (who == 2);
        chk("match_over", E_MO, 1'b0);
      end else begin
        chk("serve_after_set", E_SERVE, 1'b0);
        serve_phase("serve_set");
      end
    end else begin
      chk("serve_after_point", E_SERVE, 1'b0);
      serve_phase("serve_pt");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, start, serve timing
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_state", E_IDLE, 1'b0);
    tick();
    chk("idle_hold", E_IDLE, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_serve", E_SERVE, 1'b0);
    serve_phase("serve1");

    // 2: P1 takes the first set
    point(1);
    point(1);
    point(1);

    // 3: P2 takes two sets, match frozen, restart
    for (int i = 0; i < 6; i++) point(2);
    p1p = 1'b1;
    tick();
    p1p = 1'b0;
    chk("frozen_p1", E_MO, 1'b0);
    p2p = 1'b1;
    tick();
    p2p = 1'b0;
    chk("frozen_p2", E_MO, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_p1 = 0; m_p2 = 0; m_s1 = 0; m_s2 = 0; m_ge = 1'b0; m_ss = 1'b0;
    chk("restart", E_SERVE, 1'b0);
    serve_phase("serve_restart");

    // 4: simultaneous points
    p1p = 1'b1; p2p = 1'b1;
    tick();
    p1p = 1'b0; p2p = 1'b0;
    chk("both_points", E_SERVE, 1'b0);
    serve_phase("serve_both");

    // 5: pause inside SERVE stretches it to 14 cycles; pause in RALLY
    p2p = 1'b1;
    tick();
    p2p = 1'b0;
    m_p2++;
    chk("p2_point", E_POINT, 1'b0);
    tick();
    m_ss = 1'b0;
    chk("serve_pause_entry", E_SERVE, 1'b0);
    tick();
    chk("serve_pause_pre", E_SERVE, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("serve_paused", E_SERVE, 1'b0);
    end
    pause = 1'b0;
    tick();
    chk("serve_resume", E_SERVE, 1'b0);
    tick();
    chk("serve_resume", E_SERVE, 1'b0);
    tick();
    chk("pause_rally", E_RALLY, 1'b1);
    @(negedge clk);
    #1;
    pause = 1'b1;
    chk_mid("rally_paused_be", E_RALLY, 1'b0);
    p1p = 1'b1;
    tick();
    p1p = 1'b0;
    chk("rally_paused_ignore", E_RALLY, 1'b0);
    @(negedge clk);
    #1;
    pause = 1'b0;
    chk_mid("rally_unpaused", E_RALLY, 1'b1);

    // 6: reset mid-rally, start held through reset
    point(2);
    point(2);
    point(1);
    point(1);
    start = 1'b1;
    reset = 1'b1;
    tick();
    m_p1 = 0; m_p2 = 0; m_s1 = 0; m_s2 = 0; m_ss = 1'b0; m_ge = 1'b0; m_w = 1'b0;
    chk("reset_mid_rally", E_IDLE, 1'b0);
    tick();
    chk("reset_hold", E_IDLE, 1'b0);
    reset = 1'b0;
    tick();
    chk("held_start_ignored", E_IDLE, 1'b0);
    start = 1'b0;
    tick();
    chk("idle_after_release", E_IDLE, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fresh_start", E_SERVE, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
